bcd_bin_conv: RTL and testbench

BCD_BIN_CONV -- requirements
Module: bcd_bin_conv

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_adj.sv | 21 ++
 rtl/bcd_bin_conv.sv | 151 +++++++++++++++
 tb/tb_bcd_bin_conv.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converter: FSM state type and
// the largest value representable in a given number of BCD digits.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam state_t RESET_STATE = S_IDLE;

  // 10^ndig - 1, i.e. the largest number that fits in ndig BCD digits.
  function automatic longint unsigned bcd_limit(input int ndig);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < ndig; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction used by the shift-and-correct conversion.
// add_i = 1: digit >= 5 gets +3 (before a left shift, binary -> BCD).
// add_i = 0: digit >= 8 gets -3 (after a right shift, BCD -> binary).
// Each digit only looks at its own value.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  input  logic       add_i,
  output logic [3:0] digit_o
);

  // Conditional +3 / -3 on one digit
  always_comb begin
    digit_o = digit_i;
    if (add_i) begin
      if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
    end else begin
      if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_bin_conv.sv
// Iterative BCD <-> binary converter (double dabble / reverse double dabble).
// Handshake: in IDLE, ready is high; start sampled high at a rising edge is
// accepted together with mode/bcd_in/bin_in. Results are presented with a
// one-cycle done_tick and then held until the next completion. start is
// ignored outside IDLE. Invalid operands finish immediately with err set.
module bcd_bin_conv
  import bcd_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int W    = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic [W-1:0]      bin_in,
  output logic              ready,
  output logic              done_tick,
  output logic              err,
  output logic [W-1:0]      bin_out,
  output logic [4*NDIG-1:0] bcd_out,
  output state_t            state_dbg
);

  localparam int              BW    = 4 * NDIG;
  localparam int              CW    = $clog2(W + 1);
  localparam longint unsigned LIMIT = bcd_limit(NDIG);

  generate
    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
      $error("bcd_bin_conv: NDIG must be in 1..8");
    end
    if (W < 4 || W > 62 || (64'd1 << W) <= LIMIT) begin : g_bad_w
      $error("bcd_bin_conv: W too small to hold 10^NDIG-1");
    end
  endgenerate

  state_t         state_q, state_d;
  logic           mode_q, mode_d;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [W-1:0]   bin_out_q, bin_out_d;
  logic [BW-1:0]  bcd_out_q, bcd_out_d;

  logic [BW-1:0]  adj_in, adj_out;
  logic           bad_digit, bad_bin;

  // Operand validation on the raw inputs, used in the accepting cycle
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
    bad_bin = (64'(bin_in) > LIMIT);
  end

  // BCD->binary corrects after the right shift, binary->BCD before the left shift
  always_comb begin
    adj_in = mode_q ? bcd_q : (bcd_q >> 1);
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (adj_in[4*g +: 4]),
      .add_i   (mode_q),
      .digit_o (adj_out[4*g +: 4])
    );
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bin_out_d = bin_out_q;
    bcd_out_d = bcd_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          // The register that is shifted into must start clear
          bcd_d  = mode ? '0 : bcd_in;
          bin_d  = mode ? bin_in : '0;
          cnt_d  = CW'(W);
          err_d  = 1'b0;
          if (mode ? bad_bin : bad_digit) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_OP;
          end
        end
      end
      S_OP: begin
        cnt_d = cnt_q - CW'(1);
        if (mode_q) begin
          bcd_d = {adj_out[BW-2:0], bin_q[W-1]};
          bin_d = {bin_q[W-2:0], 1'b0};
        end else begin
          bcd_d = adj_out;
          bin_d = {bcd_q[0], bin_q[W-1:1]};
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          // Publish on entry to DONE so the result is valid with done_tick
          if (mode_q) bcd_out_d = bcd_d;
          else        bin_out_d = bin_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      mode_q    <= 1'b0;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
      bcd_out_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bin_out_q <= bin_out_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign done_tick = (state_q == S_DONE);
  assign err       = err_q;
  assign bin_out   = bin_out_q;
  assign bcd_out   = bcd_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bcd_bin_conv.sv
// Bench for bcd_bin_conv: default 4-digit instance under directed and random
// stimulus checked every cycle against an arithmetic model, plus a 2-digit
// instance swept exhaustively through both directions.
module tb_bcd_bin_conv;
  import bcd_pkg::*;

  localparam int NDIG = 4, W = 14, BW = 16;
  localparam int NDIG2 = 2, W2 = 7, BW2 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // default instance
  logic start, mode, ready, done_tick, err;
  logic [BW-1:0] bcd_in, bcd_out;
  logic [W-1:0]  bin_in, bin_out;
  state_t state_dbg;

  // small instance
  logic start_b, mode_b, ready_b, done_tick_b, err_b;
  logic [BW2-1:0] bcd_in_b, bcd_out_b;
  logic [W2-1:0]  bin_in_b, bin_out_b;
  state_t state_dbg_b;

  bcd_bin_conv #(.NDIG(NDIG), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .bcd_in(bcd_in), .bin_in(bin_in), .ready(ready), .done_tick(done_tick),
    .err(err), .bin_out(bin_out), .bcd_out(bcd_out), .state_dbg(state_dbg)
  );

  bcd_bin_conv #(.NDIG(NDIG2), .W(W2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
    .bcd_in(bcd_in_b), .bin_in(bin_in_b), .ready(ready_b), .done_tick(done_tick_b),
    .err(err_b), .bin_out(bin_out_b), .bcd_out(bcd_out_b), .state_dbg(state_dbg_b)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic longint bcd_to_int(input logic [31:0] b, input int nd);
    longint v = 0;
    for (int i = nd - 1; i >= 0; i--) v = v * 10 + longint'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [31:0] int_to_bcd(input longint v, input int nd);
    logic [31:0] r = '0;
    longint x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [31:0] b, input int nd);
    for (int i = 0; i < nd; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint max_val(input int nd);
    longint p = 1;
    repeat (nd) p = p * 10;
    return p - 1;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    bit            err;
    logic [W-1:0]  bin;
    logic [BW-1:0] bcd;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  logic [W-1:0]  hold_bin = '0, mdl_bin = '0;
  logic [BW-1:0] hold_bcd = '0, mdl_bcd = '0;
  int ncyc = 0;

  // Compare process: every negedge, outputs vs. model
  always @(negedge clk) begin
    ncyc++;
    if (!reset) begin
      if (done_tick) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done_tick=1 expected 0 at cycle %0d", ncyc);
        end else begin
          cmp_e = exp_q.pop_front();
          check("done_cycle", ncyc, cmp_e.due);
          check("err", err, cmp_e.err);
          check("bin_out", bin_out, cmp_e.bin);
          check("bcd_out", bcd_out, cmp_e.bcd);
          hold_bin = cmp_e.bin;
          hold_bcd = cmp_e.bcd;
        end
        check("ready_in_done", ready, 0);
      end else begin
        if (exp_q.size() != 0 && ncyc > exp_q[0].due) begin
          checks++;
          $display("FAIL missed_done: got no done_tick expected one at cycle %0d", exp_q[0].due);
          void'(exp_q.pop_front());
        end
        check("ready", ready, (exp_q.size() == 0) ? 1 : 0);
        check("bin_hold", bin_out, hold_bin);
        check("bcd_hold", bcd_out, hold_bcd);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      checks++;
      $display("FAIL ready_timeout: got ready=0 expected 1 within 200 cycles");
    end
  endtask

  // Issue one request; returns just after the accepting edge.
  task automatic convert(input bit m, input logic [BW-1:0] b, input logic [W-1:0] n, input bit noise);
    exp_t e;
    logic [31:0] tmp;
    wait_ready();
    start = 1'b1; mode = m; bcd_in = b; bin_in = n;
    @(posedge clk);
    e.err = m ? (longint'(n) > max_val(NDIG)) : !bcd_ok(32'(b), NDIG);
    if (!e.err) begin
      if (m) begin
        tmp = int_to_bcd(longint'(n), NDIG);
        mdl_bcd = tmp[BW-1:0];
      end else begin
        mdl_bin = W'(bcd_to_int(32'(b), NDIG));
      end
    end
    e.bin = mdl_bin;
    e.bcd = mdl_bcd;
    e.due = ncyc + (e.err ? 1 : W + 1);
    exp_q.push_back(e);
    #1 start = 1'b0;
    if (noise && !e.err) begin
      repeat (W - 2) begin
        @(negedge clk);
        start = 1'($urandom_range(0, 1));
        mode = 1'($urandom);
        bcd_in = BW'($urandom);
        bin_in = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Request on the small instance; waits for its done_tick.
  task automatic conv_b(input bit m, input logic [BW2-1:0] b, input logic [W2-1:0] n,
                        output bit o_err, output logic [W2-1:0] o_bin,
                        output logic [BW2-1:0] o_bcd, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready_b && guard < 50) begin @(negedge clk); guard++; end
    start_b = 1'b1; mode_b = m; bcd_in_b = b; bin_in_b = n;
    @(posedge clk);
    #1 start_b = 1'b0;
    lat = 0;
    o_err = 1'b0; o_bin = '0; o_bcd = '0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (done_tick_b) break;
    end
    if (done_tick_b) begin
      o_err = err_b; o_bin = bin_out_b; o_bcd = bcd_out_b;
    end else begin
      checks++;
      $display("FAIL b_done_timeout: got no done_tick expected one within 30 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] t32;
    logic [BW-1:0] rb;
    logic [W-1:0] rn;
    bit rm, rnoise;
    bit o_err;
    logic [W2-1:0] o_bin, o_bin2;
    logic [BW2-1:0] o_bcd, exp_bcd2;
    int lat;

    reset = 1'b1;
    start = 0; mode = 0; bcd_in = '0; bin_in = '0;
    start_b = 0; mode_b = 0; bcd_in_b = '0; bin_in_b = '0;

    // Pin the model with hand-computed values
    check("model_bcd2bin", bcd_to_int(32'h1234, 4), 1234);
    t32 = int_to_bcd(9999, 4);
    check("model_bin2bcd", t32, 32'h9999);
    check("model_bad_digit", bcd_ok(32'h12A4, 4), 0);
    check("model_limit", max_val(4), 9999);

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done_tick, 0);
    check("rst_err", err, 0);
    check("rst_bin", bin_out, 0);
    check("rst_bcd", bcd_out, 0);

    // Directed cases
    convert(1'b0, 16'h1234, 14'd0, 1'b0);
    wait_ready();
    check("bcd1234_bin", bin_out, 1234);
    check("bcd1234_err", err, 0);

    convert(1'b1, 16'h0000, 14'd0, 1'b0);
    wait_ready();
    check("bin0_bcd", bcd_out, 16'h0000);

    convert(1'b1, 16'hFFFF, 14'd9999, 1'b0);
    wait_ready();
    check("bin9999_bcd", bcd_out, 16'h9999);
    check("bin9999_err", err, 0);
    check("bin9999_keeps_bin", bin_out, 1234);

    convert(1'b0, 16'h12A4, 14'd0, 1'b0);
    wait_ready();
    check("bad_digit_err", err, 1);
    check("bad_digit_bin_kept", bin_out, 1234);

    convert(1'b1, 16'h0000, 14'd10000, 1'b0);
    wait_ready();
    check("over_limit_err", err, 1);
    check("over_limit_bcd_kept", bcd_out, 16'h9999);

    // start pulses and input churn during OP
    convert(1'b0, 16'h9876, 14'd0, 1'b1);
    wait_ready();
    check("noise_bin", bin_out, 9876);
    check("noise_err", err, 0);

    // Reset in the middle of a conversion
    convert(1'b0, 16'h5678, 14'd0, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    hold_bin = '0; hold_bcd = '0; mdl_bin = '0; mdl_bcd = '0;
    #2 reset = 1'b0;
    @(negedge clk);
    check("abort_ready", ready, 1);
    check("abort_done", done_tick, 0);
    check("abort_err", err, 0);
    check("abort_bin", bin_out, 0);
    check("abort_bcd", bcd_out, 0);
    repeat (W + 4) @(negedge clk);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      rm = 1'($urandom_range(0, 1));
      rb = '0;
      for (int d = 0; d < NDIG; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) rb[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
      rn = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 16383)) : W'($urandom_range(0, 9999));
      rnoise = ($urandom_range(0, 3) == 0);
      convert(rm, rb, rn, rnoise);
    end
    wait_ready();
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    // Small instance: full sweep, round trip
    for (int v = 0; v < 100; v++) begin
      t32 = int_to_bcd(v, NDIG2);
      exp_bcd2 = t32[BW2-1:0];
      conv_b(1'b1, 8'hFF, W2'(v), o_err, o_bin, o_bcd, lat);
      check("b_bcd", o_bcd, exp_bcd2);
      check("b_err1", o_err, 0);
      check("b_lat1", lat, W2 + 1);
      conv_b(1'b0, o_bcd, 7'h7F, o_err, o_bin2, o_bcd, lat);
      check("b_roundtrip", o_bin2, v);
      check("b_err0", o_err, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
